id_stage_pipe: RTL

//  Parametrised decode stage with its own register file, condition check and ID/EXE pipeline register.

---
 rtl/id_stage_pipe.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-subset decode stage with local register file, condition
// check, ID/EXE pipeline register and a saturating squash counter.
// Optional feature: define ID_WB_BYPASS_EN to forward a same-cycle WB write
// into the operand reads (write-through register file).
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       instr_i,
    input  logic              instr_valid_i,
    input  logic [31:0]       pc_i,
    input  logic              hazard_i,
    input  logic              flush_i,
    input  logic [3:0]        sr_i,
    input  logic              wb_en_i,
    input  logic [3:0]        wb_dest_i,
    input  logic [DATA_W-1:0] wb_value_i,
    output logic [3:0]        src1_o,
    output logic [3:0]        src2_o,
    output logic              two_src_o,
    output logic              ex_valid_o,
    output logic              ex_wb_en_o,
    output logic              ex_mem_r_en_o,
    output logic              ex_mem_w_en_o,
    output logic              ex_b_o,
    output logic              ex_s_o,
    output logic [3:0]        ex_exe_cmd_o,
    output logic [DATA_W-1:0] ex_val_rn_o,
    output logic [DATA_W-1:0] ex_val_rm_o,
    output logic              ex_imm_o,
    output logic [11:0]       ex_shift_operand_o,
    output logic [23:0]       ex_simm24_o,
    output logic [3:0]        ex_dest_o,
    output logic [3:0]        ex_src1_o,
    output logic [3:0]        ex_src2_o,
    output logic [31:0]       ex_pc_o,
    output logic [CNT_W-1:0]  squash_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic              mem_r;
        logic              mem_w;
        logic              b;
        logic              s;
        logic [3:0]        cmd;
        logic [DATA_W-1:0] rn;
        logic [DATA_W-1:0] rm;
        logic              imm;
        logic [11:0]       shop;
        logic [23:0]       simm;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [31:0]       pc;
    } ex_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    ex_t               ex_q, ex_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
    logic [3:0] dec_cmd;
    logic       cond_ok;
    logic [DATA_W-1:0] val_rn, val_rm;
    logic       squash;

    // Control unit: mode instr[27:26], opcode instr[24:21], S/L bit instr[20]
    always_comb begin
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_cmd = 4'b0000;
        unique case (instr_i[27:26])
            2'b00: begin
                dec_s  = instr_i[20];
                dec_wb = 1'b1;
                case (instr_i[24:21])
                    4'b1101: dec_cmd = 4'b0001;                    // MOV
                    4'b1111: dec_cmd = 4'b1001;                    // MVN
                    4'b0100: dec_cmd = 4'b0010;                    // ADD
                    4'b0101: dec_cmd = 4'b0011;                    // ADC
                    4'b0010: dec_cmd = 4'b0100;                    // SUB
                    4'b0110: dec_cmd = 4'b0101;                    // SBC
                    4'b0000: dec_cmd = 4'b0110;                    // AND
                    4'b1100: dec_cmd = 4'b0111;                    // ORR
                    4'b0001: dec_cmd = 4'b1000;                    // EOR
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end // CMP
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end // TST
                    default: begin dec_wb = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin                                           // LDR / STR
                dec_cmd = 4'b0010;
                dec_wb  = instr_i[20];
                dec_mr  = instr_i[20];
                dec_mw  = ~instr_i[20];
            end
            2'b10:   dec_b = 1'b1;
            default: ;
        endcase
    end

    // Condition check against {N,Z,C,V}; 1111 is "never"
    always_comb begin
        cond_ok = 1'b0;
        case (instr_i[31:28])
            4'h0: cond_ok = sr_i[2];
            4'h1: cond_ok = ~sr_i[2];
            4'h2: cond_ok = sr_i[1];
            4'h3: cond_ok = ~sr_i[1];
            4'h4: cond_ok = sr_i[3];
            4'h5: cond_ok = ~sr_i[3];
            4'h6: cond_ok = sr_i[0];
            4'h7: cond_ok = ~sr_i[0];
            4'h8: cond_ok = sr_i[1] & ~sr_i[2];
            4'h9: cond_ok = ~sr_i[1] | sr_i[2];
            4'hA: cond_ok = (sr_i[3] == sr_i[0]);
            4'hB: cond_ok = (sr_i[3] != sr_i[0]);
            4'hC: cond_ok = ~sr_i[2] & (sr_i[3] == sr_i[0]);
            4'hD: cond_ok = sr_i[2] | (sr_i[3] != sr_i[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign src1_o    = instr_i[19:16];
    assign src2_o    = dec_mw ? instr_i[15:12] : instr_i[3:0];
    assign two_src_o = dec_mw | ~instr_i[25];

    // Operand read; indices at or above NREGS match no entry and read 0
    always_comb begin
        val_rn = '0;
        val_rm = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src1_o == i[3:0]) val_rn = rf_q[i];
            if (src2_o == i[3:0]) val_rm = rf_q[i];
        end
`ifdef ID_WB_BYPASS_EN
        for (int i = 0; i < NREGS; i++) begin
            if (wb_en_i && wb_dest_i == i[3:0] && src1_o == i[3:0]) val_rn = wb_value_i;
            if (wb_en_i && wb_dest_i == i[3:0] && src2_o == i[3:0]) val_rm = wb_value_i;
        end
`endif
    end

    // ID/EXE next state: flush, hazard and empty slots become bubbles;
    // failed condition keeps datapath but zeroes control (annulled)
    always_comb begin
        ex_d = '0;
        if (!flush_i && !hazard_i && instr_valid_i) begin
            ex_d.valid = 1'b1;
            ex_d.rn    = val_rn;
            ex_d.rm    = val_rm;
            ex_d.imm   = instr_i[25];
            ex_d.shop  = instr_i[11:0];
            ex_d.simm  = instr_i[23:0];
            ex_d.dest  = instr_i[15:12];
            ex_d.src1  = src1_o;
            ex_d.src2  = src2_o;
            ex_d.pc    = pc_i;
            if (cond_ok) begin
                ex_d.wb_en = dec_wb;
                ex_d.mem_r = dec_mr;
                ex_d.mem_w = dec_mw;
                ex_d.b     = dec_b;
                ex_d.s     = dec_s;
                ex_d.cmd   = dec_cmd;
            end
        end
    end

    // Killed real instructions and annulled ones bump the saturating counter
    assign squash = (flush_i && instr_valid_i) ||
                    (!flush_i && !hazard_i && instr_valid_i && !cond_ok);
    assign cnt_d  = (squash && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // Pipeline register and squash counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    // Register file write port; out-of-range destinations are dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                if (wb_en_i && wb_dest_i == i[3:0]) rf_q[i] <= wb_value_i;
        end
    end

    assign ex_valid_o         = ex_q.valid;
    assign ex_wb_en_o         = ex_q.wb_en;
    assign ex_mem_r_en_o      = ex_q.mem_r;
    assign ex_mem_w_en_o      = ex_q.mem_w;
    assign ex_b_o             = ex_q.b;
    assign ex_s_o             = ex_q.s;
    assign ex_exe_cmd_o       = ex_q.cmd;
    assign ex_val_rn_o        = ex_q.rn;
    assign ex_val_rm_o        = ex_q.rm;
    assign ex_imm_o           = ex_q.imm;
    assign ex_shift_operand_o = ex_q.shop;
    assign ex_simm24_o        = ex_q.simm;
    assign ex_dest_o          = ex_q.dest;
    assign ex_src1_o          = ex_q.src1;
    assign ex_src2_o          = ex_q.src2;
    assign ex_pc_o            = ex_q.pc;
    assign squash_cnt_o       = cnt_q;

endmodule
